reg8_write_arbiter: RTL and testbench



---
 rtl/reg8_write_arbiter_pkg.sv | 26 ++
 rtl/reg8_write_arbiter_if.sv | 30 +++
 rtl/reg8_write_arbiter_rr_pick.sv | 31 +++
 rtl/reg8_write_arbiter.sv | 111 +++++++++++
 tb/tb_reg8_write_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg8_write_arbiter_pkg.sv
// Shared constants and width helpers for the shared-register write arbiter.
package reg8_write_arbiter_pkg;

   // Default configuration.
   localparam int unsigned DefNReq    = 4;
   localparam int unsigned DefWidth   = 8;
   localparam int unsigned DefMaxHold = 4;

   // Arbiter FSM states.
   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StOwn  = 1'b1;

   // Width of a requester index (ptr / owner).
   function automatic int unsigned ptr_width(input int unsigned n_req);
      return (n_req > 1) ? $clog2(n_req) : 1;
   endfunction

   // Width of the burst write counter, which must be able to hold max_hold itself.
   function automatic int unsigned cnt_width(input int unsigned max_hold);
      return $clog2(max_hold + 1);
   endfunction

   localparam int unsigned DefPtrW = ptr_width(DefNReq);
   localparam int unsigned DefCntW = cnt_width(DefMaxHold);

endpackage

// File: rtl/reg8_write_arbiter_if.sv
// Requester-side bus of the shared-register write arbiter.
interface reg8_write_arbiter_if
   import reg8_write_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ = DefNReq,
   parameter int unsigned WIDTH = DefWidth
);
   localparam int unsigned PtrW = ptr_width(N_REQ);

   logic [N_REQ-1:0]       req;
   logic [N_REQ-1:0]       lock;
   logic [N_REQ*WIDTH-1:0] wdata;
   logic [N_REQ-1:0]       gnt;
   logic [WIDTH-1:0]       Q;
   logic [PtrW-1:0]        owner;
   logic                   busy;

   // Requesters drive the request side and observe the result.
   modport master (
      output req, lock, wdata,
      input  gnt, Q, owner, busy
   );

   // The arbiter consumes requests and owns the register.
   modport slave (
      input  req, lock, wdata,
      output gnt, Q, owner, busy
   );

endinterface

// File: rtl/reg8_write_arbiter_rr_pick.sv
// Rotating priority encoder: first set request bit at or after ptr, modulo N_REQ.
module reg8_write_arbiter_rr_pick
   import reg8_write_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ = DefNReq,
   parameter int unsigned PtrW  = ptr_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PtrW-1:0]  ptr_i,
   output logic             valid_o,
   output logic [PtrW-1:0]  winner_o
);

   logic [N_REQ-1:0] rot;
   int unsigned      pos;

   // Rotate so bit 0 is the requester at ptr, find lowest set bit, rotate back.
   always_comb begin
      rot = N_REQ'({req_i, req_i} >> ptr_i);
      pos = 0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (rot[j]) pos = unsigned'(j);
      end
      pos = pos + ptr_i;
      // Explicit wrap keeps non-power-of-2 N_REQ correct.
      if (pos >= N_REQ) pos = pos - N_REQ;
      winner_o = PtrW'(pos);
      valid_o  = |req_i;
   end

endmodule

// File: rtl/reg8_write_arbiter.sv
// Single write controller for a shared WIDTH-bit register: round-robin
// arbitration with optional bounded locked bursts.
module reg8_write_arbiter
   import reg8_write_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ    = DefNReq,
   parameter int unsigned WIDTH    = DefWidth,
   parameter int unsigned MAX_HOLD = DefMaxHold
) (
   input logic                 CLK,
   input logic                 reset,
   reg8_write_arbiter_if.slave bus_io
);

   localparam int unsigned PtrW = ptr_width(N_REQ);
   localparam int unsigned CntW = cnt_width(MAX_HOLD);

   logic [0:0]       state_q, state_d;
   logic [PtrW-1:0]  ptr_q, ptr_d;
   logic [PtrW-1:0]  owner_q, owner_d;
   logic [CntW-1:0]  hold_cnt_q, hold_cnt_d;
   logic [WIDTH-1:0] reg_q, reg_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;

   logic             pick_valid;
   logic [PtrW-1:0]  pick_w;
   logic [WIDTH-1:0] lane [N_REQ];

   // Split the flat write-data bus into per-requester lanes.
   for (genvar i = 0; i < N_REQ; i++) begin : g_lane
      assign lane[i] = bus_io.wdata[i*WIDTH +: WIDTH];
   end

   reg8_write_arbiter_rr_pick #(
      .N_REQ (N_REQ),
      .PtrW  (PtrW)
   ) u_rr_pick (
      .req_i    (bus_io.req),
      .ptr_i    (ptr_q),
      .valid_o  (pick_valid),
      .winner_o (pick_w)
   );

   // Next-state: arbitrate in IDLE, serve only the burst owner in OWN.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      hold_cnt_d = hold_cnt_q;
      reg_d      = reg_q;
      gnt_d      = '0;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               reg_d   = lane[pick_w];
               gnt_d   = N_REQ'(1) << pick_w;
               owner_d = pick_w;
               ptr_d   = (pick_w == PtrW'(N_REQ - 1)) ? '0 : pick_w + 1'b1;
               if (bus_io.lock[pick_w] && (MAX_HOLD > 1)) begin
                  state_d    = StOwn;
                  hold_cnt_d = CntW'(1);
               end
            end
         end
         StOwn: begin
            // ptr already points past the owner, so no update here.
            if (bus_io.req[owner_q]) begin
               reg_d      = lane[owner_q];
               gnt_d      = N_REQ'(1) << owner_q;
               hold_cnt_d = hold_cnt_q + 1'b1;
               if (!bus_io.lock[owner_q] || (hold_cnt_q + 1'b1 == CntW'(MAX_HOLD))) begin
                  state_d    = StIdle;
                  hold_cnt_d = '0;
               end
            end else begin
               state_d    = StIdle;
               hold_cnt_d = '0;
            end
         end
         default: begin
            state_d    = StIdle;
            hold_cnt_d = '0;
         end
      endcase
   end

   // State registers; reset aborts any burst and drops an in-flight write.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         owner_q    <= '0;
         hold_cnt_q <= '0;
         reg_q      <= '0;
         gnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         hold_cnt_q <= hold_cnt_d;
         reg_q      <= reg_d;
         gnt_q      <= gnt_d;
      end
   end

   assign bus_io.Q     = reg_q;
   assign bus_io.gnt   = gnt_q;
   assign bus_io.owner = owner_q;
   assign bus_io.busy  = (state_q == StOwn);

endmodule

// File: tb/tb_reg8_write_arbiter.sv
// Self-checking bench for reg8_write_arbiter: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_reg8_write_arbiter;

   localparam int N_REQ    = 4;
   localparam int WIDTH    = 8;
   localparam int MAX_HOLD = 4;

   logic CLK = 1'b0;
   logic reset;

   reg8_write_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

   reg8_write_arbiter #(
      .N_REQ    (N_REQ),
      .WIDTH    (WIDTH),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .CLK    (CLK),
      .reset  (reset),
      .bus_io (bus.slave)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state.
   int               m_ptr;
   int               m_owner;
   bit               m_in_burst;
   int               m_writes;
   logic [WIDTH-1:0] m_q;
   logic [N_REQ-1:0] m_gnt;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic model_clear();
      m_ptr      = 0;
      m_owner    = 0;
      m_in_burst = 0;
      m_writes   = 0;
      m_q        = '0;
      m_gnt      = '0;
   endtask

   // Apply one clock edge of arbitration rules to the model.
   task automatic model_edge(input logic [N_REQ-1:0] rq, input logic [N_REQ-1:0] lk,
                             input logic [N_REQ*WIDTH-1:0] wd);
      int w;
      m_gnt = '0;
      if (m_in_burst) begin
         if (rq[m_owner]) begin
            m_q            = wd[m_owner*WIDTH +: WIDTH];
            m_gnt[m_owner] = 1'b1;
            m_writes++;
            if (!lk[m_owner] || m_writes == MAX_HOLD) m_in_burst = 0;
         end else begin
            m_in_burst = 0;
         end
      end else if (rq != 0) begin
         w = -1;
         for (int k = 0; k < N_REQ; k++) begin
            if (w < 0 && rq[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
         end
         m_q      = wd[w*WIDTH +: WIDTH];
         m_gnt[w] = 1'b1;
         m_owner  = w;
         m_ptr    = (w + 1) % N_REQ;
         if (lk[w] && MAX_HOLD > 1) begin
            m_in_burst = 1;
            m_writes   = 1;
         end
      end
   endtask

   // Synchronous-looking reset pulse spanning one edge.
   task automatic do_reset();
      reset = 1'b1;
      @(posedge CLK);
      #1;
      reset = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      bus.req   = 4'b1111;
      bus.lock  = 4'b0000;
      bus.wdata = 32'h44332211;
      reset     = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (bus.Q !== 8'h00) begin
            failures++;
            $display("FAIL reset_q: got %h expected 00", bus.Q);
         end
         checks++;
         if (bus.gnt !== 4'b0000) begin
            failures++;
            $display("FAIL reset_gnt: got %b expected 0000", bus.gnt);
         end
         checks++;
         if (bus.busy !== 1'b0 || bus.owner !== 2'd0) begin
            failures++;
            $display("FAIL reset_busy_owner: got %b/%0d expected 0/0", bus.busy, bus.owner);
         end
         tick();
      end
      reset = 1'b0;
      tick();
      checks++;
      if (bus.gnt !== 4'b0001 || bus.Q !== 8'h11) begin
         failures++;
         $display("FAIL reset_first_grant: got gnt=%b Q=%h expected 0001/11", bus.gnt, bus.Q);
      end
   endtask

   task automatic test_single();
      bus.req   = 4'b0000;
      bus.lock  = 4'b0000;
      bus.wdata = 32'h00A50000;
      do_reset();
      bus.req = 4'b0100;
      tick();
      checks++;
      if (bus.Q !== 8'hA5 || bus.gnt !== 4'b0100 || bus.owner !== 2'd2) begin
         failures++;
         $display("FAIL single_write: got Q=%h gnt=%b owner=%0d expected a5/0100/2",
                  bus.Q, bus.gnt, bus.owner);
      end
      bus.req = 4'b0000;
      tick();
      checks++;
      if (bus.gnt !== 4'b0000 || bus.Q !== 8'hA5) begin
         failures++;
         $display("FAIL single_hold: got gnt=%b Q=%h expected 0000/a5", bus.gnt, bus.Q);
      end
   endtask

   task automatic test_round_robin();
      logic [N_REQ-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [WIDTH-1:0] exp_q [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
      bus.req   = 4'b0000;
      bus.lock  = 4'b0000;
      bus.wdata = 32'h44332211;
      do_reset();
      bus.req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (bus.gnt !== exp_g[i] || bus.Q !== exp_q[i]) begin
            failures++;
            $display("FAIL rr_step%0d: got gnt=%b Q=%h expected %b/%h",
                     i, bus.gnt, bus.Q, exp_g[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_lock_max();
      logic [N_REQ-1:0] exp_g [6] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
      logic             exp_b [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      bus.req   = 4'b0000;
      bus.lock  = 4'b0000;
      bus.wdata = 32'h44332211;
      do_reset();
      bus.req  = 4'b1111;
      bus.lock = 4'b0010;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (bus.gnt !== exp_g[i] || bus.busy !== exp_b[i]) begin
            failures++;
            $display("FAIL lock_max_edge%0d: got gnt=%b busy=%b expected %b/%b",
                     i + 1, bus.gnt, bus.busy, exp_g[i], exp_b[i]);
         end
      end
   endtask

   task automatic test_lock_drop();
      bus.req   = 4'b0000;
      bus.lock  = 4'b0000;
      bus.wdata = 32'h44332211;
      do_reset();
      bus.req  = 4'b1111;
      bus.lock = 4'b0010;
      tick();
      tick();
      checks++;
      if (bus.gnt !== 4'b0010 || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL lock_drop_start: got gnt=%b busy=%b expected 0010/1", bus.gnt, bus.busy);
      end
      bus.lock = 4'b0000;
      tick();
      checks++;
      if (bus.gnt !== 4'b0010 || bus.busy !== 1'b0 || bus.Q !== 8'h22) begin
         failures++;
         $display("FAIL lock_drop_release: got gnt=%b busy=%b Q=%h expected 0010/0/22",
                  bus.gnt, bus.busy, bus.Q);
      end
      tick();
      checks++;
      if (bus.gnt !== 4'b0100) begin
         failures++;
         $display("FAIL lock_drop_next: got gnt=%b expected 0100", bus.gnt);
      end
   endtask

   task automatic test_req_drop();
      bus.req   = 4'b0000;
      bus.lock  = 4'b0000;
      bus.wdata = 32'h44332211;
      do_reset();
      bus.req  = 4'b0010;
      bus.lock = 4'b0010;
      tick();
      bus.req = 4'b0000;
      tick();
      checks++;
      if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.Q !== 8'h22) begin
         failures++;
         $display("FAIL req_drop: got gnt=%b busy=%b Q=%h expected 0000/0/22",
                  bus.gnt, bus.busy, bus.Q);
      end
      bus.req  = 4'b1111;
      bus.lock = 4'b0000;
      tick();
      checks++;
      if (bus.gnt !== 4'b0100) begin
         failures++;
         $display("FAIL req_drop_next: got gnt=%b expected 0100", bus.gnt);
      end
   endtask

   task automatic test_reset_mid_burst();
      bus.req   = 4'b0000;
      bus.lock  = 4'b0000;
      bus.wdata = 32'h44332211;
      do_reset();
      bus.req  = 4'b0010;
      bus.lock = 4'b0010;
      tick();
      tick();
      reset = 1'b1;
      #1;
      checks++;
      if (bus.Q !== 8'h00 || bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
         failures++;
         $display("FAIL reset_mid_burst: got Q=%h busy=%b gnt=%b expected 00/0/0000",
                  bus.Q, bus.busy, bus.gnt);
      end
      bus.req  = 4'b1111;
      bus.lock = 4'b0000;
      tick();
      reset = 1'b0;
      tick();
      checks++;
      if (bus.gnt !== 4'b0001 || bus.Q !== 8'h11) begin
         failures++;
         $display("FAIL reset_mid_burst_after: got gnt=%b Q=%h expected 0001/11", bus.gnt, bus.Q);
      end
   endtask

   task automatic test_random();
      bus.req   = 4'b0000;
      bus.lock  = 4'b0000;
      bus.wdata = '0;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         bus.req   = N_REQ'($urandom_range(0, 15));
         bus.lock  = N_REQ'($urandom_range(0, 15));
         bus.wdata = $urandom;
         // Favour long bursts by keeping the owner's request up.
         if (m_in_burst && $urandom_range(0, 3) != 0) bus.req[m_owner] = 1'b1;
         model_edge(bus.req, bus.lock, bus.wdata);
         tick();
         checks++;
         if (bus.gnt !== m_gnt || bus.Q !== m_q || bus.busy !== m_in_burst ||
             bus.owner !== 2'(m_owner)) begin
            failures++;
            $display("FAIL random_cycle%0d: got gnt=%b Q=%h busy=%b owner=%0d expected %b/%h/%b/%0d",
                     i, bus.gnt, bus.Q, bus.busy, bus.owner, m_gnt, m_q, m_in_burst, m_owner);
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      bus.req   = '0;
      bus.lock  = '0;
      bus.wdata = '0;
      model_clear();
      test_reset();
      test_single();
      test_round_robin();
      test_lock_max();
      test_lock_drop();
      test_req_drop();
      test_reset_mid_burst();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
